quad_mux_sequencer: RTL

QUAD_MUX_SEQUENCER -- requirements
Module: quad_mux_sequencer

---
 rtl/quad_mux_sequencer.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/quad_mux_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : quad_mux_sequencer
// Description : Steers a downstream quad 2-to-1 mux through A/B selection runs
//               from two registered operand nibbles.
// Revision    : 1.0 - initial release
// ============================================================================
module quad_mux_sequencer #(
    parameter int DWELL  = 2,
    parameter int REPEAT = 3
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       LOAD,
    input  logic [3:0] DA,
    input  logic [3:0] DB,
    input  logic       START,
    input  logic       ABORT,
    output logic       A0,
    output logic       A1,
    output logic       A2,
    output logic       A3,
    output logic       B0,
    output logic       B1,
    output logic       B2,
    output logic       B3,
    output logic       S,
    output logic       E,
    output logic       BUSY,
    output logic       DONE
);

    localparam logic [3:0] c_DWELL_M1  = 4'(DWELL - 1);
    localparam logic [3:0] c_REPEAT_M1 = 4'(REPEAT - 1);

    typedef enum logic [1:0] {
        c_IDLE  = 2'd0,
        c_SEL_A = 2'd1,
        c_SEL_B = 2'd2
    } state_t;

    state_t     r_state_q, w_state_d;
    logic [3:0] r_dwell_q, w_dwell_d;
    logic [3:0] r_pair_q,  w_pair_d;
    logic [3:0] r_opa_q,   w_opa_d;
    logic [3:0] r_opb_q,   w_opb_d;
    logic       r_e_q,     w_e_d;
    logic       r_s_q,     w_s_d;
    logic       r_busy_q,  w_busy_d;
    logic       r_done_q,  w_done_d;

    always_comb begin
        w_state_d = r_state_q;
        w_dwell_d = r_dwell_q;
        w_pair_d  = r_pair_q;
        w_opa_d   = r_opa_q;
        w_opb_d   = r_opb_q;
        w_done_d  = 1'b0;

        case (r_state_q)
            c_IDLE: begin
                w_dwell_d = 4'd0;
                w_pair_d  = 4'd0;
                if (LOAD) begin
                    w_opa_d = DA;
                    w_opb_d = DB;
                end
                if (START && !ABORT) begin
                    w_state_d = c_SEL_A;
                    w_dwell_d = c_DWELL_M1;
                    w_pair_d  = c_REPEAT_M1;
                end
            end
            c_SEL_A: begin
                if (ABORT) begin
                    w_state_d = c_IDLE;
                    w_dwell_d = 4'd0;
                    w_pair_d  = 4'd0;
                end else if (r_dwell_q == 4'd0) begin
                    w_state_d = c_SEL_B;
                    w_dwell_d = c_DWELL_M1;
                end else begin
                    w_dwell_d = r_dwell_q - 4'd1;
                end
            end
            c_SEL_B: begin
                // ABORT is tested first so it suppresses a coincident end-of-run DONE
                if (ABORT) begin
                    w_state_d = c_IDLE;
                    w_dwell_d = 4'd0;
                    w_pair_d  = 4'd0;
                end else if (r_dwell_q == 4'd0) begin
                    if (r_pair_q == 4'd0) begin
                        w_state_d = c_IDLE;
                        w_done_d  = 1'b1;
                    end else begin
                        w_state_d = c_SEL_A;
                        w_pair_d  = r_pair_q - 4'd1;
                        w_dwell_d = c_DWELL_M1;
                    end
                end else begin
                    w_dwell_d = r_dwell_q - 4'd1;
                end
            end
            default: begin
                w_state_d = c_IDLE;
                w_dwell_d = 4'd0;
                w_pair_d  = 4'd0;
            end
        endcase

        // Mux controls are decoded from the next state so they leave flops directly
        w_e_d    = (w_state_d == c_IDLE);
        w_s_d    = (w_state_d == c_SEL_B);
        w_busy_d = (w_state_d != c_IDLE);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state_q <= c_IDLE;
            r_dwell_q <= 4'd0;
            r_pair_q  <= 4'd0;
            r_opa_q   <= 4'd0;
            r_opb_q   <= 4'd0;
            r_e_q     <= 1'b1;
            r_s_q     <= 1'b0;
            r_busy_q  <= 1'b0;
            r_done_q  <= 1'b0;
        end else begin
            r_state_q <= w_state_d;
            r_dwell_q <= w_dwell_d;
            r_pair_q  <= w_pair_d;
            r_opa_q   <= w_opa_d;
            r_opb_q   <= w_opb_d;
            r_e_q     <= w_e_d;
            r_s_q     <= w_s_d;
            r_busy_q  <= w_busy_d;
            r_done_q  <= w_done_d;
        end
    end

    assign {A3, A2, A1, A0} = r_opa_q;
    assign {B3, B2, B1, B0} = r_opb_q;
    assign S    = r_s_q;
    assign E    = r_e_q;
    assign BUSY = r_busy_q;
    assign DONE = r_done_q;

endmodule
`default_nettype wire
